// File: rtl/huff_pkg.sv
// rtl/huff_pkg.sv - shared Huffman alphabet constants and decoder state encoding
package huff_pkg;

    localparam int NUM_SYM   = 10;
    localparam int MAX_LEN   = 9;
    localparam int SYM_W     = 4;
    localparam int LEN_W     = 4;
    localparam int CODE_BITS = NUM_SYM * MAX_LEN;
    localparam int LEN_BITS  = NUM_SYM * LEN_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        ERR    = 2'd2
    } huff_state_t;

    // Mask selecting the low n bits of a MAX_LEN-wide code word.
    function automatic logic [MAX_LEN-1:0] low_mask(input logic [LEN_W-1:0] n);
        low_mask = ~({MAX_LEN{1'b1}} << n);
    endfunction

endpackage

// File: rtl/huff_match.sv
// rtl/huff_match.sv - combinational codeword matcher, lowest hitting index wins
module huff_match #(
    parameter int NUM_SYM = 10,
    parameter int MAX_LEN = 9
) (
    input  logic [MAX_LEN-1:0]                 acc_n,
    input  logic [huff_pkg::LEN_W-1:0]         cnt_n,
    input  logic [NUM_SYM*MAX_LEN-1:0]         tbl_code,
    input  logic [NUM_SYM*huff_pkg::LEN_W-1:0] tbl_len,
    output logic                               hit,
    output logic [huff_pkg::SYM_W-1:0]         idx
);

    import huff_pkg::*;

    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   len_i;

    // Scan from the highest index down so the lowest hitting index is what remains.
    // Lengths of 0 or above MAX_LEN never hit, which makes those entries unused.
    always_comb begin
        mask  = ~({MAX_LEN{1'b1}} << cnt_n);
        hit   = 1'b0;
        idx   = '0;
        len_i = '0;
        for (int i = NUM_SYM - 1; i >= 0; i--) begin
            len_i = tbl_len[i*LEN_W +: LEN_W];
            if ((len_i == cnt_n) && (len_i != '0) && (len_i <= LEN_W'(MAX_LEN)) &&
                (((acc_n ^ tbl_code[i*MAX_LEN +: MAX_LEN]) & mask) == '0)) begin
                hit = 1'b1;
                idx = SYM_W'(i);
            end
        end
    end

endmodule

// File: rtl/huffman_decoder.sv
// rtl/huffman_decoder.sv - serial Huffman decoder top; HUFF_DEC_SYMCNT_EN adds a symbol counter
module huffman_decoder #(
    parameter int NUM_SYM = 10,
    parameter int MAX_LEN = 9
) (
    input  logic                               Clk_in,
    input  logic                               Rst,
    input  logic                               Load_tbl,
    input  logic [NUM_SYM*MAX_LEN-1:0]         Tbl_code,
    input  logic [NUM_SYM*huff_pkg::LEN_W-1:0] Tbl_len,
    input  logic                               Flush,
    input  logic                               Bit_in,
    input  logic                               Bit_valid,
    output logic                               Bit_ready,
    output logic [huff_pkg::SYM_W-1:0]         Sym_out,
    output logic                               Sym_valid,
    input  logic                               Sym_ready,
    output logic                               Err
`ifdef HUFF_DEC_SYMCNT_EN
    ,
    output logic [15:0]                        Sym_cnt
`endif
);

    import huff_pkg::*;

    huff_state_t state_q, state_d;

    // A codeword of MAX_LEN bits always resolves (hit or error) on its last bit,
    // so only MAX_LEN-1 received bits ever need to be held between cycles.
    logic [MAX_LEN-2:0]         acc_q, acc_d;
    logic [LEN_W-1:0]           cnt_q, cnt_d;
    logic [NUM_SYM*MAX_LEN-1:0] code_q;
    logic [NUM_SYM*LEN_W-1:0]   len_q;
    logic [SYM_W-1:0]           sym_d;
    logic                       valid_d;
    logic                       err_d;

    logic [MAX_LEN-1:0]         acc_shift;
    logic [LEN_W-1:0]           cnt_shift;
    logic                       xfer;
    logic                       hit;
    logic [SYM_W-1:0]           hit_idx;

    assign Bit_ready = (state_q == DECODE) && (!Sym_valid || Sym_ready);
    assign xfer      = Bit_valid && Bit_ready;
    assign acc_shift = {acc_q, Bit_in};
    assign cnt_shift = cnt_q + LEN_W'(1);

    huff_match #(
        .NUM_SYM (NUM_SYM),
        .MAX_LEN (MAX_LEN)
    ) u_match (
        .acc_n    (acc_shift),
        .cnt_n    (cnt_shift),
        .tbl_code (code_q),
        .tbl_len  (len_q),
        .hit      (hit),
        .idx      (hit_idx)
    );

    // Table storage: reset empties it, Load_tbl replaces it wholesale.
    always_ff @(posedge Clk_in or posedge Rst) begin
        if (Rst) begin
            code_q <= '0;
            len_q  <= '0;
        end else if (Load_tbl) begin
            code_q <= Tbl_code;
            len_q  <= Tbl_len;
        end
    end

    // State, shift register and output registers.
    always_ff @(posedge Clk_in or posedge Rst) begin
        if (Rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            Sym_out   <= '0;
            Sym_valid <= 1'b0;
            Err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            Sym_out   <= sym_d;
            Sym_valid <= valid_d;
            Err       <= err_d;
        end
    end

    // Next state: Load_tbl beats Flush, which beats a bit transfer; the output
    // handshake is applied first so a same-edge hit can re-raise Sym_valid.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sym_d   = Sym_out;
        valid_d = Sym_valid;
        err_d   = Err;

        if (Sym_valid && Sym_ready) begin
            valid_d = 1'b0;
        end

        if (Load_tbl) begin
            state_d = DECODE;
            acc_d   = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
            err_d   = 1'b0;
        end else if (Flush) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (xfer) begin
            if (hit) begin
                sym_d   = hit_idx;
                valid_d = 1'b1;
                acc_d   = '0;
                cnt_d   = '0;
            end else if (cnt_shift == LEN_W'(MAX_LEN)) begin
                state_d = ERR;
                err_d   = 1'b1;
                acc_d   = '0;
                cnt_d   = '0;
            end else begin
                acc_d = acc_shift[MAX_LEN-2:0];
                cnt_d = cnt_shift;
            end
        end
    end

`ifdef HUFF_DEC_SYMCNT_EN
    // Saturating count of consumed symbols, restarted by each table load.
    always_ff @(posedge Clk_in or posedge Rst) begin
        if (Rst) begin
            Sym_cnt <= '0;
        end else if (Load_tbl) begin
            Sym_cnt <= '0;
        end else if (Sym_valid && Sym_ready && (Sym_cnt != 16'hFFFF)) begin
            Sym_cnt <= Sym_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_huffman_decoder.sv
// tb/tb_huffman_decoder.sv - self-checking bench for huffman_decoder
module tb_huffman_decoder;

    logic        Clk_in    = 1'b0;
    logic        Rst       = 1'b1;
    logic        Load_tbl  = 1'b0;
    logic [89:0] Tbl_code  = '0;
    logic [39:0] Tbl_len   = '0;
    logic        Flush     = 1'b0;
    logic        Bit_in    = 1'b0;
    logic        Bit_valid = 1'b0;
    logic        Sym_ready = 1'b0;
    logic        Bit_ready;
    logic [3:0]  Sym_out;
    logic        Sym_valid;
    logic        Err;
`ifdef HUFF_DEC_SYMCNT_EN
    logic [15:0] Sym_cnt;
`endif

    always #5 Clk_in = ~Clk_in;

    huffman_decoder dut (
        .Clk_in    (Clk_in),
        .Rst       (Rst),
        .Load_tbl  (Load_tbl),
        .Tbl_code  (Tbl_code),
        .Tbl_len   (Tbl_len),
        .Flush     (Flush),
        .Bit_in    (Bit_in),
        .Bit_valid (Bit_valid),
        .Bit_ready (Bit_ready),
        .Sym_out   (Sym_out),
        .Sym_valid (Sym_valid),
        .Sym_ready (Sym_ready),
        .Err       (Err)
`ifdef HUFF_DEC_SYMCNT_EN
        ,
        .Sym_cnt   (Sym_cnt)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk_in);
        #1;
    endtask

    task automatic send_bit(input logic b);
        Bit_valid = 1'b1;
        Bit_in    = b;
        cyc();
        Bit_valid = 1'b0;
    endtask

    task automatic set_entry(input int i, input int code, input int len);
        Tbl_code[9*i +: 9] = 9'(code);
        Tbl_len[4*i +: 4]  = 4'(len);
    endtask

    task automatic set_test_table();
        Tbl_code = '0;
        Tbl_len  = '0;
        set_entry(0, 0, 1);
        set_entry(1, 2, 2);
        set_entry(2, 6, 3);
        set_entry(3, 14, 4);
    endtask

    task automatic pulse_load();
        Load_tbl = 1'b1;
        cyc();
        Load_tbl = 1'b0;
    endtask

    // Reference model: bits kept as a list, codewords compared as integers.
    int m_code[10];
    int m_len[10];
    bit m_loaded, m_err, m_pend;
    int m_sym, m_cnt;
    int m_bits[$];

    task automatic model_reset();
        for (int i = 0; i < 10; i++) begin
            m_code[i] = 0;
            m_len[i]  = 0;
        end
        m_loaded = 0; m_err = 0; m_pend = 0; m_sym = 0; m_cnt = 0;
        m_bits.delete();
    endtask

    function automatic bit model_ready();
        return m_loaded && !m_err && (!m_pend || Sym_ready);
    endfunction

    task automatic model_edge();
        bit rdy;
        int v, hit;
        rdy = model_ready();
        if (m_pend && Sym_ready) begin
            m_pend = 0;
            if (m_cnt < 65535) m_cnt++;
        end
        if (Load_tbl) begin
            for (int i = 0; i < 10; i++) begin
                m_code[i] = int'(Tbl_code[9*i +: 9]);
                m_len[i]  = int'(Tbl_len[4*i +: 4]);
            end
            m_loaded = 1; m_err = 0; m_pend = 0; m_cnt = 0;
            m_bits.delete();
        end else if (Flush) begin
            m_bits.delete();
        end else if (Bit_valid && rdy) begin
            m_bits.push_back(int'(Bit_in));
            v = 0;
            foreach (m_bits[k]) v = v * 2 + m_bits[k];
            hit = -1;
            for (int i = 9; i >= 0; i--) begin
                if (m_len[i] >= 1 && m_len[i] <= 9 && m_len[i] == m_bits.size() &&
                    v == (m_code[i] % (1 << m_len[i])))
                    hit = i;
            end
            if (hit >= 0) begin
                m_pend = 1;
                m_sym  = hit;
                m_bits.delete();
            end else if (m_bits.size() == 9) begin
                m_err = 1;
                m_bits.delete();
            end
        end
    endtask

    typedef struct {
        logic       b;
        logic       exp_valid;
        logic [3:0] exp_sym;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{1'b0, 1'b1, 4'd0};
        vecs[1] = '{1'b1, 1'b0, 4'd0};
        vecs[2] = '{1'b0, 1'b1, 4'd1};
        vecs[3] = '{1'b1, 1'b0, 4'd1};
        vecs[4] = '{1'b1, 1'b0, 4'd1};
        vecs[5] = '{1'b0, 1'b1, 4'd2};
        vecs[6] = '{1'b1, 1'b0, 4'd2};
        vecs[7] = '{1'b1, 1'b0, 4'd2};
        vecs[8] = '{1'b1, 1'b0, 4'd2};
        vecs[9] = '{1'b0, 1'b1, 4'd3};

        cyc();
        cyc();
        chk("rst_bit_ready", int'(Bit_ready), 0);
        chk("rst_sym_out", int'(Sym_out), 0);
        chk("rst_sym_valid", int'(Sym_valid), 0);
        chk("rst_err", int'(Err), 0);
        Rst = 1'b0;

        Bit_valid = 1'b1;
        Sym_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("idle_bit_ready", int'(Bit_ready), 0);
            chk("idle_sym_valid", int'(Sym_valid), 0);
        end
        Bit_valid = 1'b0;

        set_test_table();
        Load_tbl = 1'b1;
        #1;
        chk("preload_bit_ready", int'(Bit_ready), 0);
        cyc();
        Load_tbl = 1'b0;
        chk("load_bit_ready", int'(Bit_ready), 1);

        for (int k = 0; k < 10; k++) begin
            Bit_valid = 1'b1;
            Bit_in    = vecs[k].b;
            #1;
            chk("basic_no_bubble", int'(Bit_ready), 1);
            cyc();
            chk("basic_valid", int'(Sym_valid), int'(vecs[k].exp_valid));
            chk("basic_sym", int'(Sym_out), int'(vecs[k].exp_sym));
        end
        Bit_valid = 1'b0;
        chk("basic_err", int'(Err), 0);

        cyc();
        chk("drain_valid", int'(Sym_valid), 0);
        Sym_ready = 1'b0;
        send_bit(1'b1);
        send_bit(1'b0);
        Bit_valid = 1'b1;
        Bit_in    = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("bp_bit_ready", int'(Bit_ready), 0);
            chk("bp_valid", int'(Sym_valid), 1);
            chk("bp_sym", int'(Sym_out), 1);
            cyc();
        end
        Sym_ready = 1'b1;
        #1;
        chk("bp_release_ready", int'(Bit_ready), 1);
        cyc();
        Bit_valid = 1'b0;
        chk("bp_resume_valid", int'(Sym_valid), 1);
        chk("bp_resume_sym", int'(Sym_out), 0);
        cyc();
        chk("bp_drain_valid", int'(Sym_valid), 0);

        for (int k = 0; k < 9; k++) begin
            send_bit(1'b1);
            if (k == 7) chk("err_before_9th", int'(Err), 0);
        end
        chk("err_after_9th", int'(Err), 1);
        chk("err_bit_ready", int'(Bit_ready), 0);
        Bit_valid = 1'b1;
        cyc();
        Bit_valid = 1'b0;
        chk("err_sticky", int'(Err), 1);
        Flush = 1'b1;
        cyc();
        Flush = 1'b0;
        chk("err_flush_keeps", int'(Err), 1);
        pulse_load();
        chk("err_cleared", int'(Err), 0);
        chk("err_reload_ready", int'(Bit_ready), 1);
        send_bit(1'b0);
        chk("err_restart_valid", int'(Sym_valid), 1);
        chk("err_restart_sym", int'(Sym_out), 0);

        send_bit(1'b1);
        send_bit(1'b1);
        Flush     = 1'b1;
        Bit_valid = 1'b1;
        Bit_in    = 1'b0;
        cyc();
        Flush     = 1'b0;
        Bit_valid = 1'b0;
        chk("flush_no_sym", int'(Sym_valid), 0);
        send_bit(1'b0);
        chk("flush_valid", int'(Sym_valid), 1);
        chk("flush_sym", int'(Sym_out), 0);

        Tbl_code = '0;
        Tbl_len  = '0;
        set_entry(0, 0, 1);
        pulse_load();
        for (int k = 0; k < 3; k++) begin
            send_bit(1'b0);
            chk("single_valid", int'(Sym_valid), 1);
            chk("single_sym", int'(Sym_out), 0);
        end
        send_bit(1'b1);
        for (int k = 0; k < 8; k++) begin
            if (k == 7) chk("single_err_before", int'(Err), 0);
            send_bit(1'b0);
        end
        chk("single_err", int'(Err), 1);

        set_test_table();
        pulse_load();
        Sym_ready = 1'b0;
        send_bit(1'b0);
        chk("pend_valid", int'(Sym_valid), 1);
        Rst = 1'b1;
        #1;
        chk("arst_valid", int'(Sym_valid), 0);
        chk("arst_sym", int'(Sym_out), 0);
        chk("arst_err", int'(Err), 0);
        chk("arst_ready", int'(Bit_ready), 0);
        cyc();
        Rst       = 1'b0;
        Bit_valid = 1'b1;
        Sym_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("post_rst_ready", int'(Bit_ready), 0);
            chk("post_rst_valid", int'(Sym_valid), 0);
        end
`ifdef HUFF_DEC_SYMCNT_EN
        chk("post_rst_cnt", int'(Sym_cnt), 0);
`endif
        Bit_valid = 1'b0;

        Rst = 1'b1;
        cyc();
        Rst = 1'b0;
        model_reset();
        for (int c = 0; c < 4000; c++) begin
            Load_tbl = ($urandom_range(0, 99) < 2) || (c == 0);
            if (Load_tbl) begin
                for (int i = 0; i < 10; i++) begin
                    int r;
                    r = int'($urandom_range(0, 9));
                    if (r < 6)      set_entry(i, int'($urandom_range(0, 511)), int'($urandom_range(1, 4)));
                    else if (r < 8) set_entry(i, int'($urandom_range(0, 511)), 0);
                    else            set_entry(i, int'($urandom_range(0, 511)), int'($urandom_range(5, 15)));
                end
            end
            Flush     = ($urandom_range(0, 99) < 4);
            Bit_valid = ($urandom_range(0, 3) != 0);
            Bit_in    = 1'($urandom_range(0, 1));
            Sym_ready = ($urandom_range(0, 3) != 0);
            #1;
            chk("rnd_bit_ready", int'(Bit_ready), int'(model_ready()));
            chk("rnd_valid", int'(Sym_valid), int'(m_pend));
            chk("rnd_sym", int'(Sym_out), m_sym);
            chk("rnd_err", int'(Err), int'(m_err));
`ifdef HUFF_DEC_SYMCNT_EN
            chk("rnd_cnt", int'(Sym_cnt), m_cnt);
`endif
            model_edge();
            cyc();
        end
        Load_tbl  = 1'b0;
        Flush     = 1'b0;
        Bit_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
